// File: rtl/sd_cmd_sequencer_if.sv
// Port bundle between the command sequencer, its requester (port bus / DMA) and the SPI byte engine.
// Signal suffixes are relative to the sequencer: _i is driven into it, _o is driven by it.
interface sd_cmd_sequencer_if;
    logic        start_i;
    logic [5:0]  cmd_i;
    logic [31:0] arg_i;
    logic        busy_o;
    logic        done_o;
    logic [7:0]  r1_o;
    logic        timeout_o;
    logic [7:0]  spi_dat_o;
    logic        spi_strobe_o;
    logic        spi_busy_i;
    logic [7:0]  spi_dat_i;

    modport slave (
        input  start_i, cmd_i, arg_i, spi_busy_i, spi_dat_i,
        output busy_o, done_o, r1_o, timeout_o, spi_dat_o, spi_strobe_o
    );

    modport master (
        output start_i, cmd_i, arg_i, spi_busy_i, spi_dat_i,
        input  busy_o, done_o, r1_o, timeout_o, spi_dat_o, spi_strobe_o
    );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// Issues one SD SPI-mode command frame through the SPI byte engine and polls for the R1 response.
//   state | meaning
//   IDLE  | waiting for start_i
//   ISSUE | spi_strobe_o high for the current byte
//   GAP   | one cycle for the engine to raise its busy flag
//   WAIT  | byte in flight; advance when spi_busy_i drops
//   DONE  | done_o pulse, result valid
module sd_cmd_sequencer #(
    parameter int PRE_BYTES    = 1,
    parameter int RESP_TIMEOUT = 8
) (
    input logic                clk_i,
    input logic                rst_n_i,
    sd_cmd_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(PRE_BYTES + 7);

    localparam logic [CNT_W-1:0] IDX_CMD  = CNT_W'(PRE_BYTES);
    localparam logic [CNT_W-1:0] IDX_A3   = CNT_W'(PRE_BYTES + 1);
    localparam logic [CNT_W-1:0] IDX_A2   = CNT_W'(PRE_BYTES + 2);
    localparam logic [CNT_W-1:0] IDX_A1   = CNT_W'(PRE_BYTES + 3);
    localparam logic [CNT_W-1:0] IDX_A0   = CNT_W'(PRE_BYTES + 4);
    localparam logic [CNT_W-1:0] IDX_CRC  = CNT_W'(PRE_BYTES + 5);
    localparam logic [CNT_W-1:0] IDX_POLL = CNT_W'(PRE_BYTES + 6);
    localparam logic [7:0]       POLL_MAX = 8'(RESP_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [5:0]        cmd_q;
    logic [31:0]       arg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        poll_q;
    logic              busy_q;
    logic              done_q;
    logic [7:0]        r1_q;
    logic              tmo_q;
    logic [7:0]        spi_dat_q;
    logic              strobe_q;

    logic [6:0]        crc_d;
    logic [CNT_W-1:0]  cnt_d;
    logic [7:0]        next_byte_d;
    logic [7:0]        poll_d;

    function automatic logic [6:0] crc7(input logic [39:0] msg);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = msg[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // Filler and response-poll positions both transmit 0xFF.
    function automatic logic [7:0] frame_byte(input logic [CNT_W-1:0] idx, input logic [5:0] cmd,
                                              input logic [31:0] arg, input logic [6:0] crc);
        logic [7:0] b;
        b = 8'hFF;
        if (idx == IDX_CMD)      b = {2'b01, cmd};
        else if (idx == IDX_A3)  b = arg[31:24];
        else if (idx == IDX_A2)  b = arg[23:16];
        else if (idx == IDX_A1)  b = arg[15:8];
        else if (idx == IDX_A0)  b = arg[7:0];
        else if (idx == IDX_CRC) b = {crc, 1'b1};
        return b;
    endfunction

    always_comb begin
        crc_d       = crc7({2'b01, cmd_q, arg_q});
        cnt_d       = (cnt_q == IDX_POLL) ? cnt_q : cnt_q + 1'b1;
        next_byte_d = frame_byte(cnt_d, cmd_q, arg_q, crc_d);
        poll_d      = poll_q + 8'd1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            arg_q     <= '0;
            cnt_q     <= '0;
            poll_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            r1_q      <= 8'hFF;
            tmo_q     <= 1'b0;
            spi_dat_q <= 8'hFF;
            strobe_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        cmd_q     <= bus.cmd_i;
                        arg_q     <= bus.arg_i;
                        tmo_q     <= 1'b0;
                        r1_q      <= 8'hFF;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        poll_q    <= '0;
                        // Byte 0 is never the CRC, so its value does not matter here.
                        spi_dat_q <= frame_byte('0, bus.cmd_i, bus.arg_i, 7'h7F);
                        strobe_q  <= 1'b1;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    strobe_q <= 1'b0;
                    state_q  <= S_GAP;
                end
                S_GAP: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (!bus.spi_busy_i) begin
                        if (cnt_q == IDX_POLL) begin
                            r1_q   <= bus.spi_dat_i;
                            poll_q <= poll_d;
                            if (!bus.spi_dat_i[7]) begin
                                tmo_q   <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else if (poll_d == POLL_MAX) begin
                                tmo_q   <= 1'b1;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                spi_dat_q <= 8'hFF;
                                strobe_q  <= 1'b1;
                                state_q   <= S_ISSUE;
                            end
                        end else begin
                            cnt_q     <= cnt_d;
                            spi_dat_q <= next_byte_d;
                            strobe_q  <= 1'b1;
                            state_q   <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.r1_o         = r1_q;
    assign bus.timeout_o    = tmo_q;
    assign bus.spi_dat_o    = spi_dat_q;
    assign bus.spi_strobe_o = strobe_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Bench for sd_cmd_sequencer: SPI engine model plus a frame/response reference model.
module tb_sd_cmd_sequencer;
    localparam int PRE = 1;
    localparam int RT  = 8;

    typedef logic [7:0] bq_t[$];

    logic clk;
    logic rst_n;
    sd_cmd_sequencer_if bus();

    sd_cmd_sequencer #(.PRE_BYTES(PRE), .RESP_TIMEOUT(RT)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int  cmp_cnt = 0;
    int  fail_cnt = 0;
    bq_t tx_q;
    bq_t rx_q;
    int  eng_lat = 0;
    int  eng_len = 1;
    int  strobe_cnt = 0;
    int  xfer_done_cnt = 0;
    int  overlap_cnt = 0;
    bit  eng_idle = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SPI byte engine: busy after eng_lat cycles, for eng_len cycles, then returns next rx byte.
    initial begin
        bus.spi_busy_i = 1'b0;
        bus.spi_dat_i  = 8'hFF;
        forever begin
            @(negedge clk);
            if (rst_n && bus.spi_strobe_o) begin
                tx_q.push_back(bus.spi_dat_o);
                eng_idle = 1'b0;
                repeat (eng_lat) @(negedge clk);
                bus.spi_busy_i = 1'b1;
                repeat (eng_len) @(negedge clk);
                bus.spi_dat_i  = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hFF;
                bus.spi_busy_i = 1'b0;
                xfer_done_cnt++;
                eng_idle = 1'b1;
            end
        end
    end

    // Any strobe while a transfer is still outstanding is a protocol violation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.spi_strobe_o) begin
                if (strobe_cnt != xfer_done_cnt) overlap_cnt++;
                strobe_cnt++;
            end
        end
    end

    // CRC7 as the remainder of msg * x^7 divided by x^7 + x^3 + 1.
    function automatic logic [6:0] crc_ref(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i-:8] = r[i-:8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic void model(input logic [5:0] cmd, input logic [31:0] arg, input bq_t rx,
                                  output bq_t tx, output logic [7:0] r1, output logic tmo);
        logic [6:0] c;
        logic [7:0] b;
        int         idx;
        c = crc_ref({2'b01, cmd, arg});
        tx = {};
        for (int i = 0; i < PRE; i++) tx.push_back(8'hFF);
        tx.push_back({2'b01, cmd});
        tx.push_back(arg[31:24]);
        tx.push_back(arg[23:16]);
        tx.push_back(arg[15:8]);
        tx.push_back(arg[7:0]);
        tx.push_back({c, 1'b1});
        r1  = 8'hFF;
        tmo = 1'b1;
        for (int k = 0; k < RT; k++) begin
            idx = PRE + 6 + k;
            b = (idx < rx.size()) ? rx[idx] : 8'hFF;
            tx.push_back(8'hFF);
            r1 = b;
            if (b[7] == 1'b0) begin
                tmo = 1'b0;
                break;
            end
        end
    endfunction

    task automatic kick(input logic [5:0] cmd, input logic [31:0] arg);
        @(negedge clk);
        bus.cmd_i   = cmd;
        bus.arg_i   = arg;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic collect(input int max_cyc, output bit got, output logic [7:0] r1,
                           output logic tmo, output logic busy_at_done, output logic done_after);
        got = 1'b0; r1 = 8'h00; tmo = 1'b0; busy_at_done = 1'b1; done_after = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) begin
                got          = 1'b1;
                r1           = bus.r1_o;
                tmo          = bus.timeout_o;
                busy_at_done = bus.busy_o;
                @(negedge clk);
                done_after   = bus.done_o;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.start_i = 1'b0; bus.cmd_i = '0; bus.arg_i = '0;
        #12;
        cmp_cnt += 6;
        if (bus.busy_o !== 1'b0)       begin fail_cnt++; $display("FAIL reset_busy got %0b want 0", bus.busy_o); end
        if (bus.done_o !== 1'b0)       begin fail_cnt++; $display("FAIL reset_done got %0b want 0", bus.done_o); end
        if (bus.r1_o !== 8'hFF)        begin fail_cnt++; $display("FAIL reset_r1 got %h want ff", bus.r1_o); end
        if (bus.timeout_o !== 1'b0)    begin fail_cnt++; $display("FAIL reset_timeout got %0b want 0", bus.timeout_o); end
        if (bus.spi_dat_o !== 8'hFF)   begin fail_cnt++; $display("FAIL reset_spi_dat got %h want ff", bus.spi_dat_o); end
        if (bus.spi_strobe_o !== 1'b0) begin fail_cnt++; $display("FAIL reset_strobe got %0b want 0", bus.spi_strobe_o); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        cmp_cnt++;
        if (strobe_cnt != 0) begin fail_cnt++; $display("FAIL idle_no_strobe got %0d want 0", strobe_cnt); end
    endtask

    task automatic test_cmd0;
        logic [7:0] want [8];
        bit got; logic [7:0] r1; logic tmo, bd, da;
        want = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF};
        tx_q = {};
        rx_q = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
        eng_lat = 0; eng_len = 2;
        kick(6'd0, 32'h0);
        collect(500, got, r1, tmo, bd, da);
        cmp_cnt += 6;
        if (!got) begin fail_cnt++; $display("FAIL cmd0_done got none want pulse"); end
        if (tx_q.size() != 8) begin fail_cnt++; $display("FAIL cmd0_count got %0d want 8", tx_q.size()); end
        for (int i = 0; i < 8 && i < tx_q.size(); i++) begin
            cmp_cnt++;
            if (tx_q[i] !== want[i]) begin fail_cnt++; $display("FAIL cmd0_byte%0d got %h want %h", i, tx_q[i], want[i]); end
        end
        if (r1 !== 8'h01) begin fail_cnt++; $display("FAIL cmd0_r1 got %h want 01", r1); end
        if (tmo !== 1'b0) begin fail_cnt++; $display("FAIL cmd0_timeout got %0b want 0", tmo); end
        if (bd !== 1'b0)  begin fail_cnt++; $display("FAIL cmd0_busy_at_done got %0b want 0", bd); end
        if (da !== 1'b0)  begin fail_cnt++; $display("FAIL cmd0_done_width got %0b want 0", da); end
    endtask

    task automatic test_cmd8;
        logic [7:0] want [9];
        bit got; logic [7:0] r1; logic tmo, bd, da;
        want = '{8'hFF, 8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87, 8'hFF, 8'hFF};
        tx_q = {};
        // Frame-phase replies with bit 7 clear must be ignored.
        rx_q = {8'h00, 8'h05, 8'h7F, 8'h00, 8'h12, 8'h00, 8'h3C, 8'hFF, 8'h01, 8'h00};
        eng_lat = 1; eng_len = 3;
        kick(6'd8, 32'h0000_01AA);
        collect(500, got, r1, tmo, bd, da);
        cmp_cnt += 4;
        if (!got) begin fail_cnt++; $display("FAIL cmd8_done got none want pulse"); end
        if (tx_q.size() != 9) begin fail_cnt++; $display("FAIL cmd8_count got %0d want 9", tx_q.size()); end
        for (int i = 0; i < 9 && i < tx_q.size(); i++) begin
            cmp_cnt++;
            if (tx_q[i] !== want[i]) begin fail_cnt++; $display("FAIL cmd8_byte%0d got %h want %h", i, tx_q[i], want[i]); end
        end
        if (r1 !== 8'h01) begin fail_cnt++; $display("FAIL cmd8_r1 got %h want 01", r1); end
        if (tmo !== 1'b0) begin fail_cnt++; $display("FAIL cmd8_timeout got %0b want 0", tmo); end
    endtask

    task automatic test_timeout;
        bit got; logic [7:0] r1; logic tmo, bd, da;
        tx_q = {}; rx_q = {};
        eng_lat = 0; eng_len = 1;
        kick(6'd55, 32'hDEAD_BEEF);
        collect(800, got, r1, tmo, bd, da);
        cmp_cnt += 6;
        if (!got) begin fail_cnt++; $display("FAIL tmo_done got none want pulse"); end
        if (tx_q.size() != PRE + 6 + RT) begin fail_cnt++; $display("FAIL tmo_count got %0d want %0d", tx_q.size(), PRE + 6 + RT); end
        if (r1 !== 8'hFF) begin fail_cnt++; $display("FAIL tmo_r1 got %h want ff", r1); end
        if (tmo !== 1'b1) begin fail_cnt++; $display("FAIL tmo_flag got %0b want 1", tmo); end
        if (bd !== 1'b0)  begin fail_cnt++; $display("FAIL tmo_busy_at_done got %0b want 0", bd); end
        if (da !== 1'b0)  begin fail_cnt++; $display("FAIL tmo_done_width got %0b want 0", da); end
    endtask

    task automatic test_random;
        bq_t want; bq_t rx_copy;
        logic [7:0] wr1; logic wtmo;
        bit got; logic [7:0] r1; logic tmo, bd, da;
        logic [5:0] cmd; logic [31:0] arg; logic [7:0] b;
        for (int n = 0; n < 12; n++) begin
            cmd = 6'($urandom); arg = $urandom;
            rx_q = {};
            for (int i = 0; i < PRE + 6; i++) rx_q.push_back(8'($urandom));
            for (int i = 0; i < RT + 2; i++) begin
                b = 8'($urandom);
                b[7] = ($urandom_range(0, 3) != 0);
                rx_q.push_back(b);
            end
            rx_copy = rx_q;
            model(cmd, arg, rx_copy, want, wr1, wtmo);
            eng_lat = $urandom_range(0, 1);
            eng_len = $urandom_range(1, 6);
            tx_q = {};
            kick(cmd, arg);
            collect(2000, got, r1, tmo, bd, da);
            cmp_cnt += 5;
            if (!got) begin fail_cnt++; $display("FAIL rnd%0d_done got none want pulse", n); end
            if (tx_q.size() != want.size()) begin fail_cnt++; $display("FAIL rnd%0d_count got %0d want %0d", n, tx_q.size(), want.size()); end
            for (int i = 0; i < want.size() && i < tx_q.size(); i++) begin
                cmp_cnt++;
                if (tx_q[i] !== want[i]) begin fail_cnt++; $display("FAIL rnd%0d_byte%0d got %h want %h", n, i, tx_q[i], want[i]); end
            end
            if (r1 !== wr1)   begin fail_cnt++; $display("FAIL rnd%0d_r1 got %h want %h", n, r1, wr1); end
            if (tmo !== wtmo) begin fail_cnt++; $display("FAIL rnd%0d_timeout got %0b want %0b", n, tmo, wtmo); end
            if (da !== 1'b0)  begin fail_cnt++; $display("FAIL rnd%0d_done_width got %0b want 0", n, da); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic test_ignore_start;
        bq_t want; bq_t rx_copy;
        logic [7:0] wr1; logic wtmo;
        bit got; logic [7:0] r1; logic tmo, bd, da;
        rx_q = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h05};
        rx_copy = rx_q;
        model(6'd24, 32'h1234_5678, rx_copy, want, wr1, wtmo);
        eng_lat = 0; eng_len = 2;
        tx_q = {};
        kick(6'd24, 32'h1234_5678);
        repeat (6) @(negedge clk);
        bus.cmd_i = 6'd17; bus.arg_i = 32'hA5A5_5A5A; bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        collect(800, got, r1, tmo, bd, da);
        cmp_cnt += 3;
        if (!got) begin fail_cnt++; $display("FAIL ign_done got none want pulse"); end
        if (tx_q.size() != want.size()) begin fail_cnt++; $display("FAIL ign_count got %0d want %0d", tx_q.size(), want.size()); end
        for (int i = 0; i < want.size() && i < tx_q.size(); i++) begin
            cmp_cnt++;
            if (tx_q[i] !== want[i]) begin fail_cnt++; $display("FAIL ign_byte%0d got %h want %h", i, tx_q[i], want[i]); end
        end
        if (r1 !== 8'h05) begin fail_cnt++; $display("FAIL ign_r1 got %h want 05", r1); end
    endtask

    task automatic test_back_to_back;
        bq_t want; bq_t rx_copy;
        logic [7:0] wr1; logic wtmo;
        bit got; logic [7:0] r1; logic tmo, bd, da;
        rx_q = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        eng_lat = 0; eng_len = 1;
        tx_q = {};
        @(negedge clk);
        bus.cmd_i = 6'd41; bus.arg_i = 32'h4000_0000; bus.start_i = 1'b1;
        collect(800, got, r1, tmo, bd, da);
        // collect returns in the first IDLE cycle after DONE, with start_i still high.
        cmp_cnt += 4;
        if (!got) begin fail_cnt++; $display("FAIL b2b_first_done got none want pulse"); end
        if (bus.busy_o !== 1'b0) begin fail_cnt++; $display("FAIL b2b_idle_busy got %0b want 0", bus.busy_o); end
        if (bus.spi_strobe_o !== 1'b0) begin fail_cnt++; $display("FAIL b2b_idle_strobe got %0b want 0", bus.spi_strobe_o); end
        if (tx_q.size() != PRE + 7) begin fail_cnt++; $display("FAIL b2b_first_count got %0d want %0d", tx_q.size(), PRE + 7); end
        tx_q = {};
        rx_q = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h09};
        rx_copy = rx_q;
        model(6'd41, 32'h4000_0000, rx_copy, want, wr1, wtmo);
        @(negedge clk);
        bus.start_i = 1'b0;
        cmp_cnt += 2;
        if (bus.busy_o !== 1'b1) begin fail_cnt++; $display("FAIL b2b_restart_busy got %0b want 1", bus.busy_o); end
        if (bus.spi_strobe_o !== 1'b1) begin fail_cnt++; $display("FAIL b2b_restart_strobe got %0b want 1", bus.spi_strobe_o); end
        collect(800, got, r1, tmo, bd, da);
        cmp_cnt += 3;
        if (!got) begin fail_cnt++; $display("FAIL b2b_second_done got none want pulse"); end
        if (tx_q.size() != want.size()) begin fail_cnt++; $display("FAIL b2b_second_count got %0d want %0d", tx_q.size(), want.size()); end
        if (r1 !== wr1) begin fail_cnt++; $display("FAIL b2b_second_r1 got %h want %h", r1, wr1); end
    endtask

    task automatic test_slow_engine;
        bit got; logic [7:0] r1; logic tmo, bd, da;
        int s0;
        rx_q = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
        eng_lat = 1; eng_len = 40;
        tx_q = {};
        s0 = strobe_cnt;
        kick(6'd9, 32'h0);
        collect(3000, got, r1, tmo, bd, da);
        cmp_cnt += 4;
        if (!got) begin fail_cnt++; $display("FAIL slow_done got none want pulse"); end
        if (strobe_cnt - s0 != PRE + 9) begin fail_cnt++; $display("FAIL slow_strobes got %0d want %0d", strobe_cnt - s0, PRE + 9); end
        if (overlap_cnt != 0) begin fail_cnt++; $display("FAIL slow_overlap got %0d want 0", overlap_cnt); end
        if (r1 !== 8'h01) begin fail_cnt++; $display("FAIL slow_r1 got %h want 01", r1); end
    endtask

    task automatic test_reset_mid;
        int s0;
        bit reached;
        rx_q = {};
        eng_lat = 0; eng_len = 4;
        tx_q = {};
        kick(6'd17, 32'h0102_0304);
        reached = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_q.size() >= PRE + 3) begin reached = 1'b1; break; end
        end
        #2 rst_n = 1'b0;
        #1;
        cmp_cnt += 6;
        if (!reached) begin fail_cnt++; $display("FAIL rstmid_reach got %0d bytes want %0d", tx_q.size(), PRE + 3); end
        if (bus.busy_o !== 1'b0)       begin fail_cnt++; $display("FAIL rstmid_busy got %0b want 0", bus.busy_o); end
        if (bus.spi_strobe_o !== 1'b0) begin fail_cnt++; $display("FAIL rstmid_strobe got %0b want 0", bus.spi_strobe_o); end
        if (bus.spi_dat_o !== 8'hFF)   begin fail_cnt++; $display("FAIL rstmid_spi_dat got %h want ff", bus.spi_dat_o); end
        if (bus.r1_o !== 8'hFF)        begin fail_cnt++; $display("FAIL rstmid_r1 got %h want ff", bus.r1_o); end
        if (bus.done_o !== 1'b0)       begin fail_cnt++; $display("FAIL rstmid_done got %0b want 0", bus.done_o); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50 && !eng_idle; i++) @(negedge clk);
        rx_q = {};
        s0 = strobe_cnt;
        repeat (25) @(negedge clk);
        cmp_cnt += 2;
        if (strobe_cnt != s0) begin fail_cnt++; $display("FAIL rstmid_no_resume got %0d strobes want 0", strobe_cnt - s0); end
        if (bus.busy_o !== 1'b0) begin fail_cnt++; $display("FAIL rstmid_idle_busy got %0b want 0", bus.busy_o); end
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_cmd8();
        test_timeout();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_slow_engine();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
